tile_walker: RTL and testbench

// - Sequences the brute-force search across the grid's tile FSMs.
// - Grants exactly one tile its turn at a time, then waits for that tile's forward or back pulse.
// - Advances to the next tile on a forward pulse and backtracks to the previous tile on a back pulse.
// - Reports solved / unsolvable / error status to the top level and drives the tiles' synchronous reset.

---
 rtl/tile_walker.sv | 157 +++++++++++++++
 tb/tb_tile_walker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_walker.sv
// tile_walker: sequences the brute-force search across the grid's tile FSMs.
// It grants one tile its turn at a time and waits for that tile's forward or
// back pulse. A forward pulse moves the search to the next tile and a back
// pulse moves it to the previous tile. It reports solved / unsolvable / error
// status and drives the tiles' synchronous reset.
//
// Ports
//   clock        in   single clock, posedge
//   reset_n      in   asynchronous active-low reset
//   start        in   begin a solve (honoured in IDLE and the DONE states)
//   abort        in   cancel a solve in progress, back to IDLE
//   tiles_reset  out  one-cycle synchronous reset pulse for all tiles
//   myturn       out  one-hot, one-cycle grant; bit i goes to tile i
//   passfwd      in   tile i found a legal value
//   passbak      in   tile i exhausted its values
//   cur_tile     out  index of the tile holding the turn
//   busy         out  high outside IDLE / DONE_OK / DONE_FAIL
//   done         out  solve finished, held until the next start
//   success      out  valid with done: grid solved
//   timeout      out  sticky: grant limit reached
//   protocol_err out  sticky: illegal pass pulse seen
//   step_count   out  grants issued in this solve, saturating
module tile_walker #(
  parameter int unsigned NUM_TILES = 81,
  parameter int unsigned IDX_W     = 7,
  parameter int unsigned STEP_W    = 32,
  parameter int unsigned MAX_STEPS = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 tiles_reset,
  output logic [NUM_TILES-1:0] myturn,
  input  logic [NUM_TILES-1:0] passfwd,
  input  logic [NUM_TILES-1:0] passbak,
  output logic [IDX_W-1:0]     cur_tile,
  output logic                 busy,
  output logic                 done,
  output logic                 success,
  output logic                 timeout,
  output logic                 protocol_err,
  output logic [STEP_W-1:0]    step_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_GRANT, S_WAIT, S_DONE_OK, S_DONE_FAIL
  } state_t;

  localparam logic [IDX_W-1:0] LAST_TILE = IDX_W'(NUM_TILES - 1);

  state_t               r_state, w_next;
  logic [IDX_W-1:0]     r_cur_tile, w_cur_next;
  logic [STEP_W-1:0]    r_step_count, w_step_inc;
  logic                 r_timeout, r_protocol_err;
  logic                 w_clear, w_set_to, w_set_perr;
  logic [NUM_TILES-1:0] w_sel, w_others;
  logic                 w_fwd, w_bak, w_bad;

  always_comb begin
    w_sel = '0;
    w_sel[r_cur_tile] = 1'b1;
  end

  assign w_fwd      = |(passfwd & w_sel);
  assign w_bak      = |(passbak & w_sel);
  assign w_others   = (passfwd | passbak) & ~w_sel;
  // Both pulses from the current tile, or any pulse from another tile, is an error
  assign w_bad      = (w_fwd & w_bak) | (|w_others);
  assign w_step_inc = (&r_step_count) ? r_step_count : r_step_count + STEP_W'(1);

  always_comb begin
    w_next     = r_state;
    w_cur_next = r_cur_tile;
    w_clear    = 1'b0;
    w_set_to   = 1'b0;
    w_set_perr = 1'b0;
    case (r_state)
      S_IDLE, S_DONE_OK, S_DONE_FAIL: begin
        // abort is irrelevant here, so start wins when both are high
        if (start) begin
          w_next     = S_CLEAR;
          w_clear    = 1'b1;
          w_cur_next = '0;
        end
      end
      S_CLEAR:  w_next = abort ? S_IDLE : S_SETTLE;
      S_SETTLE: w_next = abort ? S_IDLE : S_GRANT;
      S_GRANT: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if ((MAX_STEPS != 0) && (w_step_inc >= STEP_W'(MAX_STEPS))) begin
          w_next   = S_DONE_FAIL;
          w_set_to = 1'b1;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_bad) begin
          w_next     = S_DONE_FAIL;
          w_set_perr = 1'b1;
        end else if (w_fwd) begin
          if (r_cur_tile == LAST_TILE) begin
            w_next = S_DONE_OK;
          end else begin
            w_next     = S_GRANT;
            w_cur_next = r_cur_tile + IDX_W'(1);
          end
        end else if (w_bak) begin
          if (r_cur_tile == '0) begin
            w_next = S_DONE_FAIL;
          end else begin
            w_next     = S_GRANT;
            w_cur_next = r_cur_tile - IDX_W'(1);
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_cur_tile     <= '0;
      r_step_count   <= '0;
      r_timeout      <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cur_tile <= w_cur_next;
      if (w_clear) begin
        r_step_count   <= '0;
        r_timeout      <= 1'b0;
        r_protocol_err <= 1'b0;
      end else begin
        if (r_state == S_GRANT) r_step_count <= w_step_inc;
        if (w_set_to)           r_timeout <= 1'b1;
        if (w_set_perr)         r_protocol_err <= 1'b1;
      end
    end
  end

  assign tiles_reset  = (r_state == S_CLEAR);
  assign myturn       = (r_state == S_GRANT) ? w_sel : '0;
  assign cur_tile     = r_cur_tile;
  assign busy         = (r_state != S_IDLE) && (r_state != S_DONE_OK) && (r_state != S_DONE_FAIL);
  assign done         = (r_state == S_DONE_OK) || (r_state == S_DONE_FAIL);
  assign success      = (r_state == S_DONE_OK);
  assign timeout      = r_timeout;
  assign protocol_err = r_protocol_err;
  assign step_count   = r_step_count;

endmodule

// File: tb/tb_tile_walker.sv
// Bench for tile_walker with four tiles. Instance a has no grant limit and
// instance b has a limit of 5. Behavioural tiles reply from per-tile scripts
// (1 = back, otherwise forward).
module tb_tile_walker;
  localparam int N = 4;

  logic clock = 1'b0;
  logic reset_n, start_a, start_b, abort, auto_en, sel;
  logic [N-1:0] pf_auto, pb_auto, pf_man, pb_man, passfwd, passbak;

  logic [N-1:0]  myturn_a, myturn_b;
  logic [1:0]    cur_a, cur_b;
  logic [31:0]   step_a, step_b;
  logic trst_a, trst_b, busy_a, busy_b, done_a, done_b, succ_a, succ_b;
  logic to_a, to_b, perr_a, perr_b;

  logic [N-1:0] obs_turn;
  logic [1:0]   obs_cur;
  logic [31:0]  obs_step;
  logic obs_trst, obs_busy, obs_done, obs_succ, obs_to, obs_perr;

  int n_checks, n_errors;
  int scr[N][$];
  int ptr[N];
  int grants[$];
  int exp_grants[$];
  int trst_cnt, wide_cnt;

  always #5 clock = ~clock;

  assign passfwd = pf_auto | pf_man;
  assign passbak = pb_auto | pb_man;

  tile_walker #(.NUM_TILES(N), .IDX_W(2), .STEP_W(32), .MAX_STEPS(0)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .abort(abort),
    .tiles_reset(trst_a), .myturn(myturn_a), .passfwd(passfwd), .passbak(passbak),
    .cur_tile(cur_a), .busy(busy_a), .done(done_a), .success(succ_a),
    .timeout(to_a), .protocol_err(perr_a), .step_count(step_a));

  tile_walker #(.NUM_TILES(N), .IDX_W(2), .STEP_W(32), .MAX_STEPS(5)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .abort(abort),
    .tiles_reset(trst_b), .myturn(myturn_b), .passfwd(passfwd), .passbak(passbak),
    .cur_tile(cur_b), .busy(busy_b), .done(done_b), .success(succ_b),
    .timeout(to_b), .protocol_err(perr_b), .step_count(step_b));

  assign obs_turn = sel ? myturn_b : myturn_a;
  assign obs_cur  = sel ? cur_b    : cur_a;
  assign obs_step = sel ? step_b   : step_a;
  assign obs_trst = sel ? trst_b   : trst_a;
  assign obs_busy = sel ? busy_b   : busy_a;
  assign obs_done = sel ? done_b   : done_a;
  assign obs_succ = sel ? succ_b   : succ_a;
  assign obs_to   = sel ? to_b     : to_a;
  assign obs_perr = sel ? perr_b   : perr_a;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference walk: grant, consume the tile's next scripted reply, move.
  task automatic model_walk(input int maxs, output bit ok, output bit to, output int steps);
    int p[N];
    int idx;
    int r;
    bit fin;
    for (int t = 0; t < N; t++) p[t] = 0;
    idx = 0; steps = 0; ok = 0; to = 0; fin = 0;
    exp_grants.delete();
    while (!fin) begin
      exp_grants.push_back(idx);
      steps++;
      if (maxs != 0 && steps >= maxs) begin
        to = 1; fin = 1;
      end else begin
        r = (p[idx] < scr[idx].size()) ? scr[idx][p[idx]] : 0;
        p[idx]++;
        if (r == 1) begin
          if (idx == 0) fin = 1; else idx--;
        end else begin
          if (idx == N - 1) begin ok = 1; fin = 1; end else idx++;
        end
      end
    end
  endtask

  // Behavioural tiles: reply 3 cycles after a grant, forget state on tiles_reset.
  initial begin
    int rsp_cnt;
    int rsp_tile;
    logic [N-1:0] prev;
    rsp_cnt = 0; rsp_tile = 0; prev = '0;
    pf_auto = '0; pb_auto = '0; trst_cnt = 0; wide_cnt = 0;
    for (int t = 0; t < N; t++) ptr[t] = 0;
    forever begin
      @(negedge clock);
      pf_auto = '0; pb_auto = '0;
      if (obs_trst) begin
        trst_cnt++;
        rsp_cnt = 0;
        for (int t = 0; t < N; t++) ptr[t] = 0;
      end
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0 && auto_en) begin
          if (ptr[rsp_tile] < scr[rsp_tile].size() && scr[rsp_tile][ptr[rsp_tile]] == 1)
            pb_auto[rsp_tile] = 1'b1;
          else
            pf_auto[rsp_tile] = 1'b1;
          ptr[rsp_tile]++;
        end
      end
      if (obs_turn != '0) begin
        if (prev != '0) wide_cnt++;
        for (int i = 0; i < N; i++) if (obs_turn[i]) rsp_tile = i;
        grants.push_back(rsp_tile);
        rsp_cnt = 3;
      end
      prev = obs_turn;
    end
  end

  task automatic clear_scripts();
    for (int t = 0; t < N; t++) scr[t].delete();
  endtask

  task automatic pulse_start();
    @(negedge clock);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic run_solve(input string nm, input bit chk_lat);
    bit eok, eto;
    int esteps, gbase, tbase, wbase, lat, cyc;
    model_walk(sel ? 5 : 0, eok, eto, esteps);
    gbase = grants.size(); tbase = trst_cnt; wbase = wide_cnt;
    pulse_start();
    lat = 1;
    while (obs_turn == '0 && lat < 20) begin @(negedge clock); lat++; end
    if (chk_lat) check_eq({nm, "_first_grant_lat"}, lat, 3);
    cyc = 0;
    while (!obs_done && cyc < 3000) begin @(negedge clock); cyc++; end
    check_eq({nm, "_done"}, obs_done, 1);
    check_eq({nm, "_success"}, obs_succ, eok);
    check_eq({nm, "_timeout"}, obs_to, eto);
    check_eq({nm, "_perr"}, obs_perr, 0);
    check_eq({nm, "_busy"}, obs_busy, 0);
    check_eq({nm, "_steps"}, obs_step, esteps);
    repeat (6) @(negedge clock);
    check_eq({nm, "_steps_hold"}, obs_step, esteps);
    check_eq({nm, "_done_hold"}, obs_done, 1);
    check_eq({nm, "_tiles_reset_cnt"}, trst_cnt - tbase, 1);
    check_eq({nm, "_wide_turn"}, wide_cnt - wbase, 0);
    check_eq({nm, "_grant_cnt"}, grants.size() - gbase, exp_grants.size());
    for (int i = 0; i < exp_grants.size() && gbase + i < grants.size(); i++)
      check_eq({nm, "_grant_order"}, grants[gbase + i], exp_grants[i]);
  endtask

  initial begin
    int cyc;
    n_checks = 0; n_errors = 0;
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    pf_man = '0; pb_man = '0; auto_en = 1'b1; sel = 1'b0;
    clear_scripts();
    #1;
    check_eq("rst_myturn", obs_turn, 0);
    check_eq("rst_cur", obs_cur, 0);
    check_eq("rst_step", obs_step, 0);
    check_eq("rst_trst", obs_trst, 0);
    check_eq("rst_done", obs_done, 0);
    check_eq("rst_success", obs_succ, 0);
    check_eq("rst_timeout", obs_to, 0);
    check_eq("rst_perr", obs_perr, 0);
    check_eq("rst_busy", obs_busy, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // 1: all forward
    clear_scripts();
    run_solve("t1", 1'b1);
    // 2: tile 2 backs once
    clear_scripts(); scr[2].push_back(1);
    run_solve("t2", 1'b0);
    // 3: tile 0 backs on first grant
    clear_scripts(); scr[0].push_back(1);
    run_solve("t3", 1'b0);

    // 4: stray pass from tile 3 while tile 1 holds the turn
    clear_scripts(); auto_en = 1'b0;
    pulse_start();
    cyc = 0;
    while (obs_turn == '0 && cyc < 20) begin @(negedge clock); cyc++; end
    check_eq("t4_grant0", obs_turn, 1);
    @(negedge clock); pf_man = 4'b0001;
    @(negedge clock); pf_man = '0;
    check_eq("t4_grant1", obs_turn, 2);
    check_eq("t4_cur1", obs_cur, 1);
    @(negedge clock); pf_man = 4'b1000;
    @(negedge clock); pf_man = '0;
    check_eq("t4_done", obs_done, 1);
    check_eq("t4_perr", obs_perr, 1);
    check_eq("t4_success", obs_succ, 0);
    check_eq("t4_myturn", obs_turn, 0);
    repeat (6) @(negedge clock);
    auto_en = 1'b1;

    // 5: timeout instance, tiles 1 and 2 keep backtracking
    sel = 1'b1;
    clear_scripts();
    scr[2].push_back(1); scr[2].push_back(1); scr[2].push_back(1);
    scr[1].push_back(0); scr[1].push_back(1);
    run_solve("t5", 1'b0);
    sel = 1'b0;

    // 6a: async reset while waiting on a tile
    clear_scripts();
    pulse_start();
    cyc = 0;
    while (obs_turn == '0 && cyc < 20) begin @(negedge clock); cyc++; end
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6a_busy", obs_busy, 0);
    check_eq("t6a_step", obs_step, 0);
    check_eq("t6a_myturn", obs_turn, 0);
    check_eq("t6a_done", obs_done, 0);
    @(negedge clock); reset_n = 1'b1;
    repeat (6) @(negedge clock);
    run_solve("t6a_rerun", 1'b1);

    // 6b: abort during grant
    pulse_start();
    cyc = 0;
    while (obs_turn == '0 && cyc < 20) begin @(negedge clock); cyc++; end
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    check_eq("t6b_busy", obs_busy, 0);
    check_eq("t6b_done", obs_done, 0);
    check_eq("t6b_myturn", obs_turn, 0);
    repeat (6) @(negedge clock);
    check_eq("t6b_idle_busy", obs_busy, 0);
    run_solve("t6b_rerun", 1'b0);

    // randomized scripts on both instances
    for (int r = 0; r < 12; r++) begin
      sel = 1'($urandom_range(0, 1));
      clear_scripts();
      for (int t = 0; t < N; t++) begin
        int len;
        len = $urandom_range(0, 2);
        for (int k = 0; k < len; k++)
          scr[t].push_back(($urandom_range(0, 99) < 40) ? 1 : 0);
      end
      run_solve($sformatf("rnd%0d", r), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
